lcd_dma_read_arbiter: RTL and testbench
=======================================

Name: lcd_dma_read_arbiter

Overview:
- Shares the single burst-read DMA port between two requesters: client 0 is the LCD framebuffer FIFO fetch, client 1 is a secondary reader such as an overlay or palette loader.
- Sequences each burst: grant, DMA_START pulse, address hold, data steering, completion detect.
- Client 0 has fixed priority; a streak limit guarantees client 1 is not starved.
- Sits between the client FIFOs and the DMA engine, all in the CLK domain.

Parameters:
- BURST_LEN, 8: data beats expected per DMA burst; beat counter width is $clog2(BURST_LEN+1).
- MAX_C0_STREAK, 4: maximum consecutive client-0 grants while client 1 is waiting. Legal range 1..15.

Ports:
- CLK  in  1  clock for all logic.
- RESET  in  1  synchronous reset, active-high.
- C0_REQ  in  1  client 0 burst request, level; hold with C0_ADDR stable until C0_ACK.
- C0_ADDR  in  29  client 0 burst start address, 8-byte word units.
- C0_ACK  out  1  one-cycle pulse when client 0's request is issued.
- C0_RD_DATA  out  32  read data to client 0, broadcast copy of DMA_RD_DATA.
- C0_RD_DATA_VALID  out  1  data beat for client 0.
- C0_DONE  out  1  one-cycle pulse when client 0's burst completes.
- C1_REQ, C1_ADDR, C1_ACK, C1_RD_DATA, C1_RD_DATA_VALID, C1_DONE: same as client 0, for client 1.
- DMA_RD_ADDR  out  29  burst address to DMA; held stable for the whole burst.
- DMA_START  out  1  one-cycle pulse starting a burst.
- DMA_READY  in  1  DMA idle/ready.
- DMA_RD_DATA  in  32  DMA read data.
- DMA_RD_DATA_VALID  in  1  DMA data beat strobe.
- ERR_BEATS  out  1  sticky: a burst completed with a beat count different from BURST_LEN.

Behaviour:
- Reset values (RESET=1 at a CLK edge): state IDLE; all ACK/DONE/VALID outputs 0; DMA_START 0; DMA_RD_ADDR 0; ERR_BEATS 0; streak counter 0; owner 0; beat counter 0. RESET mid-burst abandons the burst with no DONE pulse. The DMA engine is reset by the same RESET.
- State IDLE: arbitration happens only when DMA_READY=1 and (C0_REQ or C1_REQ).
  - Winner is client 1 if C1_REQ and (not C0_REQ, or streak == MAX_C0_STREAK); otherwise client 0.
  - Registered on that edge: owner, DMA_RD_ADDR <= winner's ADDR, beat counter <= 0. Next state is ISSUE.
- Streak counter:
  - On a client-0 grant with C1_REQ=1: increments, saturating at MAX_C0_STREAK.
  - On a client-0 grant with C1_REQ=0: set to 0.
  - On a client-1 grant: set to 0.
- State ISSUE (exactly 1 cycle): DMA_START=1 and owner's ACK=1. Next state is WAIT_BUSY. Latency is 1 cycle from REQ sampled in IDLE to DMA_START.
- State WAIT_BUSY: waits for DMA_READY=0, then goes to BUSY. The DMA_READY=1 still visible during ISSUE is ignored.
- State BUSY:
  - Owner's RD_DATA_VALID = DMA_RD_DATA_VALID, combinational, gated by owner. The non-owner's VALID is always 0.
  - Each valid beat increments the beat counter, saturating.
  - When DMA_READY=1: go to DONE.
- VALID beats arriving in WAIT_BUSY are also forwarded and counted.
- State DONE (1 cycle): owner's DONE=1. If beat counter != BURST_LEN, ERR_BEATS <= 1. Next state is IDLE.
- Back-to-back bursts: DONE -> IDLE -> ISSUE, so a minimum of 2 cycles separates the last DMA_READY rise from the next DMA_START.
- REQ still high after DONE is treated as a new request in IDLE.
- DMA_RD_ADDR changes only in IDLE on a grant, and is never modified during WAIT_BUSY, BUSY or DONE.
- REQ dropped before ACK: the request is withdrawn with no effect. Once granted, the burst always runs to completion.
- Cx_RD_DATA = DMA_RD_DATA, unregistered, for both clients.

Optional Feature:
- Macro LCD_DMA_ARB_STATS_EN.
- When defined, adds ports:
  - STAT_C0_BURSTS out 16 and STAT_C1_BURSTS out 16: wrapping count of DONE pulses per client.
  - STAT_MAX_WAIT out 8: saturating maximum of cycles any REQ was high before its ACK.
- All three reset to 0.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single C0 request, ADDR=0x1000000, DMA model of 8 beats over 16 cycles:
  - DMA_START 1 cycle after REQ; C0_ACK coincident with it.
  - 8 C0_RD_DATA_VALID beats; C0_DONE once.
  - DMA_RD_ADDR stable at 0x1000000 throughout; ERR_BEATS=0.
- Only C1 requesting, ADDR=0x20: C1 receives all 8 beats; C0_RD_DATA_VALID stays 0 throughout.
- C0_REQ and C1_REQ held high continuously, MAX_C0_STREAK=4: grant sequence is C0,C0,C0,C0,C1,C0,C0,C0,C0,C1.
- DMA model returns 7 beats: ERR_BEATS rises in the DONE cycle and stays 1 until RESET.
- RESET asserted mid-BUSY: next cycle all outputs are at reset values and no DONE pulse occurs; a new C0 request afterwards completes normally.
- With LCD_DMA_ARB_STATS_EN: 3 C0 bursts then 2 C1 bursts give STAT_C0_BURSTS=3 and STAT_C1_BURSTS=2; STAT_MAX_WAIT equals the measured longest C1 wait.

Source files
------------

// File: rtl/lcd_dma_read_arbiter.sv
// Two-client burst-read arbiter in front of the LCD DMA engine: client 0 (framebuffer fetch) has fixed priority,
// bounded by a streak limit so client 1 is not starved. Optional statistics are enabled with LCD_DMA_ARB_STATS_EN.
module lcd_dma_read_arbiter #(
    parameter int BURST_LEN     = 8,
    parameter int MAX_C0_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        C0_REQ,
    input  logic [28:0] C0_ADDR,
    output logic        C0_ACK,
    output logic [31:0] C0_RD_DATA,
    output logic        C0_RD_DATA_VALID,
    output logic        C0_DONE,
    input  logic        C1_REQ,
    input  logic [28:0] C1_ADDR,
    output logic        C1_ACK,
    output logic [31:0] C1_RD_DATA,
    output logic        C1_RD_DATA_VALID,
    output logic        C1_DONE,
    output logic [28:0] DMA_RD_ADDR,
    output logic        DMA_START,
    input  logic        DMA_READY,
    input  logic [31:0] DMA_RD_DATA,
    input  logic        DMA_RD_DATA_VALID,
`ifdef LCD_DMA_ARB_STATS_EN
    output logic [15:0] STAT_C0_BURSTS,
    output logic [15:0] STAT_C1_BURSTS,
    output logic [7:0]  STAT_MAX_WAIT,
`endif
    output logic        ERR_BEATS
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BEATS_EXP  = BW'(BURST_LEN);
    localparam logic [BW-1:0] BEAT_ONE   = BW'(1);
    localparam logic [BW-1:0] BEAT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BEAT_MAX   = {BW{1'b1}};
    localparam logic [3:0]    STREAK_MAX = 4'(MAX_C0_STREAK);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_BUSY      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [28:0]     addr_q, addr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [3:0]      streak_q, streak_d;
    logic            err_q, err_d;
    logic            dma_start_q;
    logic            ack0_q, ack1_q;
    logic            done0_q, done1_q;
    logic            c1_win_s;
    logic            beat_window_s;

    // Next-state, arbitration, streak and beat accounting.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        beat_d   = beat_q;
        streak_d = streak_q;
        err_d    = err_q;
        c1_win_s = C1_REQ && (!C0_REQ || (streak_q == STREAK_MAX));

        case (state_q)
            ST_IDLE: begin
                if (DMA_READY && (C0_REQ || C1_REQ)) begin
                    state_d = ST_ISSUE;
                    owner_d = c1_win_s;
                    beat_d  = BEAT_ZERO;
                    if (c1_win_s) begin
                        addr_d   = C1_ADDR;
                        streak_d = 4'd0;
                    end else begin
                        addr_d = C0_ADDR;
                        // Streak only grows while client 1 is actually being held off.
                        if (!C1_REQ) begin
                            streak_d = 4'd0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end else begin
                            streak_d = streak_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!DMA_READY) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_WAIT_BUSY;
                end
            end
            ST_BUSY: begin
                if (DMA_READY) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (beat_window_s && DMA_RD_DATA_VALID && (beat_q != BEAT_MAX)) begin
            beat_d = beat_q + BEAT_ONE;
        end else begin
            beat_d = beat_d;
        end

        // Flag lands together with the DONE pulse, using the final beat count.
        if ((state_q == ST_BUSY) && DMA_READY && (beat_d != BEATS_EXP)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State register and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            addr_q      <= 29'd0;
            beat_q      <= BEAT_ZERO;
            streak_q    <= 4'd0;
            err_q       <= 1'b0;
            dma_start_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            streak_q    <= streak_d;
            err_q       <= err_d;
            dma_start_q <= (state_d == ST_ISSUE);
            ack0_q      <= (state_d == ST_ISSUE) && !owner_d;
            ack1_q      <= (state_d == ST_ISSUE) && owner_d;
            done0_q     <= (state_d == ST_DONE) && !owner_d;
            done1_q     <= (state_d == ST_DONE) && owner_d;
        end
    end

    assign beat_window_s    = (state_q == ST_WAIT_BUSY) || (state_q == ST_BUSY);
    assign C0_RD_DATA_VALID = DMA_RD_DATA_VALID && beat_window_s && !owner_q;
    assign C1_RD_DATA_VALID = DMA_RD_DATA_VALID && beat_window_s && owner_q;
    assign C0_RD_DATA       = DMA_RD_DATA;
    assign C1_RD_DATA       = DMA_RD_DATA;
    assign C0_ACK           = ack0_q;
    assign C1_ACK           = ack1_q;
    assign C0_DONE          = done0_q;
    assign C1_DONE          = done1_q;
    assign DMA_START        = dma_start_q;
    assign DMA_RD_ADDR      = addr_q;
    assign ERR_BEATS        = err_q;

`ifdef LCD_DMA_ARB_STATS_EN
    logic [15:0] c0_bursts_q, c1_bursts_q;
    logic [7:0]  wait0_q, wait1_q, max_wait_q;

    // Burst counters and request-to-ack wait tracking.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            c0_bursts_q <= 16'd0;
            c1_bursts_q <= 16'd0;
            wait0_q     <= 8'd0;
            wait1_q     <= 8'd0;
            max_wait_q  <= 8'd0;
        end else begin
            if (done0_q) begin
                c0_bursts_q <= c0_bursts_q + 16'd1;
            end
            if (done1_q) begin
                c1_bursts_q <= c1_bursts_q + 16'd1;
            end
            if (ack0_q || !C0_REQ) begin
                wait0_q <= 8'd0;
            end else if (wait0_q != 8'hFF) begin
                wait0_q <= wait0_q + 8'd1;
            end
            if (ack1_q || !C1_REQ) begin
                wait1_q <= 8'd0;
            end else if (wait1_q != 8'hFF) begin
                wait1_q <= wait1_q + 8'd1;
            end
            // Only one ACK can be high at a time, so one comparison per cycle suffices.
            if (ack0_q && (wait0_q > max_wait_q)) begin
                max_wait_q <= wait0_q;
            end else if (ack1_q && (wait1_q > max_wait_q)) begin
                max_wait_q <= wait1_q;
            end
        end
    end

    assign STAT_C0_BURSTS = c0_bursts_q;
    assign STAT_C1_BURSTS = c1_bursts_q;
    assign STAT_MAX_WAIT  = max_wait_q;
`endif

endmodule

// File: tb/tb_lcd_dma_read_arbiter.sv
// Scoreboard bench for lcd_dma_read_arbiter: stimulus queues expected grants, beats and completions;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_lcd_dma_read_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        C0_REQ, C1_REQ;
    logic [28:0] C0_ADDR, C1_ADDR;
    logic        C0_ACK, C1_ACK, C0_DONE, C1_DONE;
    logic        C0_RD_DATA_VALID, C1_RD_DATA_VALID;
    logic [31:0] C0_RD_DATA, C1_RD_DATA;
    logic [28:0] DMA_RD_ADDR;
    logic        DMA_START;
    logic        DMA_READY;
    logic [31:0] DMA_RD_DATA;
    logic        DMA_RD_DATA_VALID;
    logic        ERR_BEATS;
`ifdef LCD_DMA_ARB_STATS_EN
    logic [15:0] STAT_C0_BURSTS, STAT_C1_BURSTS;
    logic [7:0]  STAT_MAX_WAIT;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_beats = 8;
    int done_cnt = 0, beat_cnt = 0, c0_done_cnt = 0, c1_done_cnt = 0;
    logic [29:0] grant_q[$];
    logic [32:0] beat_q[$];
    logic [1:0]  done_q[$];
    logic        in_burst = 1'b0;
    logic [28:0] cur_addr = 29'd0;

    lcd_dma_read_arbiter #(.BURST_LEN(8), .MAX_C0_STREAK(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .C0_REQ(C0_REQ), .C0_ADDR(C0_ADDR), .C0_ACK(C0_ACK), .C0_RD_DATA(C0_RD_DATA),
        .C0_RD_DATA_VALID(C0_RD_DATA_VALID), .C0_DONE(C0_DONE),
        .C1_REQ(C1_REQ), .C1_ADDR(C1_ADDR), .C1_ACK(C1_ACK), .C1_RD_DATA(C1_RD_DATA),
        .C1_RD_DATA_VALID(C1_RD_DATA_VALID), .C1_DONE(C1_DONE),
        .DMA_RD_ADDR(DMA_RD_ADDR), .DMA_START(DMA_START), .DMA_READY(DMA_READY),
        .DMA_RD_DATA(DMA_RD_DATA), .DMA_RD_DATA_VALID(DMA_RD_DATA_VALID),
`ifdef LCD_DMA_ARB_STATS_EN
        .STAT_C0_BURSTS(STAT_C0_BURSTS), .STAT_C1_BURSTS(STAT_C1_BURSTS), .STAT_MAX_WAIT(STAT_MAX_WAIT),
`endif
        .ERR_BEATS(ERR_BEATS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [28:0] a, input int b);
        return {a[23:0], b[7:0]};
    endfunction

    function automatic logic [63:0] out_vec();
        return 64'({C0_ACK, C1_ACK, C0_DONE, C1_DONE, C0_RD_DATA_VALID, C1_RD_DATA_VALID,
                    DMA_START, ERR_BEATS, DMA_RD_ADDR});
    endfunction

    task automatic push_burst(input logic c, input logic [28:0] a, input int nb, input logic err);
        grant_q.push_back({c, a});
        for (int i = 0; i < nb; i++) beat_q.push_back({c, beat_data(a, i)});
        done_q.push_back({c, err});
    endtask

    // Monitor: compares every grant, beat and completion the DUT presents.
    always @(negedge CLK) begin
        logic [29:0] g;
        logic [32:0] b;
        logic [1:0]  d;
        if (RESET) begin
            in_burst = 1'b0;
        end else begin
            if (DMA_START || C0_ACK || C1_ACK) begin
                if (grant_q.size() == 0) begin
                    check("grant_unexpected", 64'({DMA_START, C1_ACK, C0_ACK}), 64'(0));
                end else begin
                    g = grant_q.pop_front();
                    check("grant", 64'({DMA_START, C1_ACK, C0_ACK, DMA_RD_ADDR}),
                          64'({1'b1, g[29], ~g[29], g[28:0]}));
                    cur_addr = g[28:0];
                    in_burst = 1'b1;
                end
            end else if (in_burst) begin
                check("addr_hold", 64'(DMA_RD_ADDR), 64'(cur_addr));
            end
            if (C0_RD_DATA_VALID || C1_RD_DATA_VALID) begin
                if (beat_q.size() == 0) begin
                    check("beat_unexpected", 64'({C1_RD_DATA_VALID, C0_RD_DATA_VALID}), 64'(0));
                end else begin
                    b = beat_q.pop_front();
                    beat_cnt++;
                    check("beat_owner", 64'({C1_RD_DATA_VALID, C0_RD_DATA_VALID}), 64'({b[32], ~b[32]}));
                    check("beat_data", {C1_RD_DATA, C0_RD_DATA}, {b[31:0], b[31:0]});
                end
            end
            if (C0_DONE || C1_DONE) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 64'({C1_DONE, C0_DONE}), 64'(0));
                end else begin
                    d = done_q.pop_front();
                    check("done", 64'({C1_DONE, C0_DONE, ERR_BEATS}), 64'({d[1], ~d[1], d[0]}));
                    in_burst = 1'b0;
                    done_cnt++;
                    if (d[1]) c1_done_cnt++;
                    else c0_done_cnt++;
                end
            end
        end
    end

`ifdef LCD_DMA_ARB_STATS_EN
    int c1_wait = 0, c1_wait_max = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            c1_wait = 0;
            c1_wait_max = 0;
        end else if (C1_ACK) begin
            if (c1_wait > c1_wait_max) c1_wait_max = c1_wait;
            c1_wait = 0;
        end else if (C1_REQ) begin
            c1_wait++;
        end else begin
            c1_wait = 0;
        end
    end
`endif

    // DMA model: drops READY after START, returns n_beats beats on even cycles of a 16-cycle window.
    task automatic run_burst();
        int nb;
        logic [28:0] a;
        logic abort;
        nb = n_beats;
        a = DMA_RD_ADDR;
        abort = 1'b0;
        @(posedge CLK); #2;
        DMA_READY = 1'b0;
        for (int i = 0; i < 16 && !abort; i++) begin
            @(posedge CLK); #2;
            if (RESET) begin
                abort = 1'b1;
            end else begin
                DMA_RD_DATA_VALID = ((i % 2) == 0) && ((i / 2) < nb);
                DMA_RD_DATA = DMA_RD_DATA_VALID ? beat_data(a, i / 2) : 32'h0;
            end
        end
        if (!abort) begin
            @(posedge CLK); #2;
        end
        DMA_RD_DATA_VALID = 1'b0;
        DMA_RD_DATA = 32'h0;
        DMA_READY = 1'b1;
    endtask

    initial begin
        DMA_READY = 1'b1;
        DMA_RD_DATA_VALID = 1'b0;
        DMA_RD_DATA = 32'h0;
        forever begin
            @(negedge CLK);
            if (DMA_START && !RESET) run_burst();
        end
    end

    task automatic issue_req(input logic c, input logic [28:0] a);
        int n;
        logic seen;
        @(posedge CLK); #1;
        if (c) begin C1_ADDR = a; C1_REQ = 1'b1; end
        else begin C0_ADDR = a; C0_REQ = 1'b1; end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge CLK); #1;
            n++;
            seen = c ? C1_ACK : C0_ACK;
        end
        check("req_to_ack_cycles", 64'(n), 64'(2));
        @(posedge CLK); #1;
        C0_REQ = 1'b0;
        C1_REQ = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        if (done_cnt < target) check("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic do_req(input logic c, input logic [28:0] a, input int nb, input logic err);
        int target;
        target = done_cnt + 1;
        n_beats = nb;
        push_burst(c, a, nb, err);
        issue_req(c, a);
        wait_done(target, 100);
    endtask

    initial begin
        int base;
        RESET = 1'b1;
        C0_REQ = 1'b0; C1_REQ = 1'b0;
        C0_ADDR = 29'd0; C1_ADDR = 29'd0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_outputs", out_vec(), 64'(0));

        do_req(1'b0, 29'h1000000, 8, 1'b0);
        do_req(1'b1, 29'h0000020, 8, 1'b0);

        // Both clients hold requests: C0 x4, C1, C0 x4, C1.
        n_beats = 8;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) push_burst(1'b1, 29'h0000300, 8, 1'b0);
            else push_burst(1'b0, 29'h0000100, 8, 1'b0);
        end
        base = done_cnt;
        @(posedge CLK); #1;
        C0_ADDR = 29'h0000100; C1_ADDR = 29'h0000300;
        C0_REQ = 1'b1; C1_REQ = 1'b1;
        wait_done(base + 10, 400);
        @(posedge CLK); #1;
        C0_REQ = 1'b0; C1_REQ = 1'b0;

        do_req(1'b0, 29'h0000440, 7, 1'b1);
        repeat (3) @(negedge CLK);
        check("err_sticky", 64'(ERR_BEATS), 64'(1));
        do_req(1'b1, 29'h1FFFFFF8, 8, 1'b1);

`ifdef LCD_DMA_ARB_STATS_EN
        @(negedge CLK);
        check("stat_bursts", 64'({STAT_C0_BURSTS, STAT_C1_BURSTS}), 64'({16'(c0_done_cnt), 16'(c1_done_cnt)}));
        check("stat_max_wait", 64'(STAT_MAX_WAIT), 64'(c1_wait_max));
`endif

        // Reset in the middle of a burst: only the grant and two beats are expected.
        n_beats = 8;
        grant_q.push_back({1'b0, 29'h0000500});
        beat_q.push_back({1'b0, beat_data(29'h0000500, 0)});
        beat_q.push_back({1'b0, beat_data(29'h0000500, 1)});
        base = beat_cnt;
        issue_req(1'b0, 29'h0000500);
        for (int n = 0; n < 100 && beat_cnt < base + 2; n++) begin
            @(negedge CLK); #1;
        end
        check("beats_before_reset", 64'(beat_cnt), 64'(base + 2));
        base = done_cnt;
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        check("reset_mid_burst", out_vec(), 64'(0));
        repeat (30) @(negedge CLK);
        check("no_done_after_reset", 64'(done_cnt), 64'(base));

        do_req(1'b0, 29'h0ABCDEF, 8, 1'b0);

        check("grant_q_empty", 64'(grant_q.size()), 64'(0));
        check("beat_q_empty", 64'(beat_q.size()), 64'(0));
        check("done_q_empty", 64'(done_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
